// File: rtl/axis_frame_sink.sv
// axis_frame_sink: AXI-stream pixel sink that writes a frame to a frame-store port and checks last framing.
// One output register stage decouples the stream from frame-store backpressure.
module axis_frame_sink #(
    parameter  int DATA_W = 8,
    parameter  int COLS   = 1024,
    parameter  int ROWS   = 1024,
    localparam int NPIX   = COLS * ROWS,
    localparam int CNT_W  = $clog2(NPIX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [CNT_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err_early_last,
    output logic              err_missing_last,
    output logic [CNT_W-1:0]  pix_cnt
);
    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

    state_t             state_q, state_d;
    logic               wr_en_q, wr_en_d;
    logic [CNT_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               err_early_q, err_early_d;
    logic               err_miss_q, err_miss_d;
    logic               frame_done_q, frame_done_d;
    logic               accept;
    logic               last_beat;

    // Ready only needs the output register to be empty or draining this cycle.
    assign s_ready   = (state_q == RECV || state_q == FLUSH) && (!wr_en_q || wr_ready);
    assign accept    = s_valid && s_ready;
    assign last_beat = pix_cnt_q == CNT_W'(NPIX - 1);

    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q && !wr_ready;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        pix_cnt_d    = pix_cnt_q;
        err_early_d  = err_early_q;
        err_miss_d   = err_miss_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d     = RECV;
                pix_cnt_d   = '0;
                err_early_d = 1'b0;
                err_miss_d  = 1'b0;
            end
            RECV: if (accept) begin
                wr_en_d   = 1'b1;
                wr_addr_d = pix_cnt_q;
                wr_data_d = s_data;
                pix_cnt_d = pix_cnt_q + 1'b1;
                if (last_beat) begin
                    state_d    = s_last ? DONE : FLUSH;
                    err_miss_d = err_miss_q | !s_last;
                end else if (s_last) begin
                    state_d     = DONE;
                    err_early_d = 1'b1;
                end
            end
            FLUSH: if (accept && s_last) state_d = DONE;
            DONE: if (!wr_en_q) begin
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            pix_cnt_q    <= '0;
            err_early_q  <= 1'b0;
            err_miss_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            pix_cnt_q    <= pix_cnt_d;
            err_early_q  <= err_early_d;
            err_miss_q   <= err_miss_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_en            = wr_en_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign pix_cnt          = pix_cnt_q;
    assign busy             = state_q != IDLE;
    assign frame_done       = frame_done_q;
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_miss_q;
endmodule
